// File: rtl/data_mem_unit_if.sv
// Request/response bus between the MEM stage and the data memory.
// Handshake: a request transfers on any rising edge where req_valid && req_ready; rsp_valid is a single-cycle pulse.
interface data_mem_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_unit.sv
// Bounded RV32I data memory: wait states, byte-lane store merge, load extension and fault reporting.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_unit_if.slave bus,
  output logic [1:0]    state_dbg
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] BYTE_LIM = (ADDR_W+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;

  logic              accept, commit;
  logic              illegal, misal, oor;
  logic [1:0]        fault;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word, merged, wd, shifted, load_data;
  logic [3:0]        be;

  logic [31:0]       mem [DEPTH_WORDS];

  assign accept   = bus.req_valid && bus.req_ready;
  assign commit   = (state == ACCESS) && (cnt == 4'd0);
  assign word_idx = a_addr[IDX_W+1:2];
  assign rd_word  = mem[word_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0)   state_nxt = RESP;
      RESP:    state_nxt = bus.req_valid ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state != ACCESS);
    bus.rsp_valid = (state == RESP);
    state_dbg     = state;
  end

  // Request fields are captured only on a handshake, so the pipeline may change them during ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      a_we    <= 1'b0;
      a_f3    <= 3'd0;
      a_addr  <= '0;
      a_wdata <= 32'd0;
    end else if (accept) begin
      cnt     <= 4'(WAIT_STATES);
      a_we    <= bus.req_we;
      a_f3    <= bus.req_funct3;
      a_addr  <= bus.req_addr;
      a_wdata <= bus.req_wdata;
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    if (a_we) illegal = (a_f3 > 3'd2);
    else      illegal = !(a_f3 == 3'd0 || a_f3 == 3'd1 || a_f3 == 3'd2 ||
                          a_f3 == 3'd4 || a_f3 == 3'd5);
    case (a_f3[1:0])
      2'b01:   misal = a_addr[0];
      2'b10:   misal = |a_addr[1:0];
      default: misal = 1'b0;
    endcase
    oor = ({1'b0, a_addr} >= BYTE_LIM);
    if (illegal)    fault = 2'b11;
    else if (misal) fault = 2'b01;
    else if (oor)   fault = 2'b10;
    else            fault = 2'b00;
  end

  always_comb begin
    case (a_f3[1:0])
      2'b00: begin
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = a_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Legal halves are 2-byte aligned, so one byte-granular shift serves both widths.
  always_comb begin
    shifted = rd_word >> {a_addr[1:0], 3'b000};
    case (a_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      3'b010:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && a_we && fault == 2'b00) mem[word_idx] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_rdata <= 32'd0;
      bus.rsp_fault <= 2'b00;
    end else if (commit) begin
      bus.rsp_fault <= fault;
      bus.rsp_rdata <= (a_we || fault != 2'b00) ? 32'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one instance with no wait states, one with three.
module tb_data_mem_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_unit_if #(.ADDR_W(32)) if0 ();
  data_mem_unit_if #(.ADDR_W(32)) if3 ();
  logic [1:0] st0, st3;

  data_mem_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .ADDR_W(32)) u0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .state_dbg(st0));
  data_mem_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .ADDR_W(32)) u3 (
    .clk(clk), .reset(reset), .bus(if3.slave), .state_dbg(st3));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          d;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_funct3 = f3;
      if0.req_addr = addr; if0.req_wdata = wdata;
    end else begin
      if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3;
      if3.req_addr = addr; if3.req_wdata = wdata;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? if0.req_ready : if3.req_ready;
  endfunction
  function automatic logic get_rsp_valid(input int d);
    return (d == 0) ? if0.rsp_valid : if3.rsp_valid;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? if0.rsp_rdata : if3.rsp_rdata;
  endfunction
  function automatic logic [1:0] get_fault(input int d);
    return (d == 0) ? if0.rsp_fault : if3.rsp_fault;
  endfunction

  // Counts negedges from the handshake cycle to the response cycle.
  task automatic wait_rsp(input int d, output int lat, output int ready_low);
    lat = 1;
    ready_low = 0;
    while (!get_rsp_valid(d) && lat < 50) begin
      if (!get_ready(d)) ready_low++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_req(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic [1:0] fault,
                         output int lat, output int ready_low);
    int g;
    @(negedge clk);
    drive(d, 1'b1, we, f3, addr, wdata);
    g = 0;
    while (!get_ready(d) && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    wait_rsp(d, lat, ready_low);
    rdata = get_rdata(d);
    fault = get_fault(d);
  endtask

  function automatic void add(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] er, input logic [1:0] ef);
    vec_t v;
    v.d = d; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_fault = ef;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  ft;
    int          lat, rl, seen;

    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    // WAIT_STATES=0 instance: basic widths, merges and faults
    add(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        2'b00);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00);
    add(0, 1, 3'b010, 32'h10,  32'h11223344, 32'h0,        2'b00);
    add(0, 1, 3'b000, 32'h13,  32'h12345680, 32'h0,        2'b00);
    add(0, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 2'b00);
    add(0, 0, 3'b100, 32'h13,  32'h0,        32'h00000080, 2'b00);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'h80223344, 2'b00);
    add(0, 0, 3'b000, 32'h10,  32'h0,        32'h00000044, 2'b00);
    add(0, 0, 3'b001, 32'h12,  32'h0,        32'hFFFF8022, 2'b00);
    add(0, 0, 3'b101, 32'h10,  32'h0,        32'h00003344, 2'b00);
    add(0, 1, 3'b010, 32'h20,  32'h0,        32'h0,        2'b00);
    add(0, 1, 3'b001, 32'h22,  32'h1234A5A5, 32'h0,        2'b00);
    add(0, 0, 3'b001, 32'h22,  32'h0,        32'hFFFFA5A5, 2'b00);
    add(0, 0, 3'b101, 32'h22,  32'h0,        32'h0000A5A5, 2'b00);
    add(0, 0, 3'b010, 32'h20,  32'h0,        32'hA5A50000, 2'b00);
    add(0, 0, 3'b010, 32'h11,  32'h0,        32'h0,        2'b01);
    add(0, 1, 3'b010, 32'h0,   32'h00000055, 32'h0,        2'b00);
    add(0, 1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0,       2'b10);
    add(0, 0, 3'b010, 32'h0,   32'h0,        32'h00000055, 2'b00);
    add(0, 0, 3'b011, 32'h10,  32'h0,        32'h0,        2'b11);
    add(0, 1, 3'b001, 32'h1001, 32'hFFFF,    32'h0,        2'b01);
    add(0, 1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,        2'b11);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'h80223344, 2'b00);
    add(0, 0, 3'b110, 32'h1003, 32'h0,       32'h0,        2'b11);
    add(0, 0, 3'b001, 32'h1002, 32'h0,       32'h0,        2'b10);
    add(0, 0, 3'b001, 32'h21,  32'h0,        32'h0,        2'b01);
    add(0, 1, 3'b010, 32'hFFC, 32'h0BADCAFE, 32'h0,        2'b00);
    add(0, 0, 3'b010, 32'hFFC, 32'h0,        32'h0BADCAFE, 2'b00);
    add(0, 0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        2'b10);
    // WAIT_STATES=3 instance
    add(3, 1, 3'b010, 32'h40,  32'h11111111, 32'h0,        2'b00);
    add(3, 0, 3'b010, 32'h40,  32'h0,        32'h11111111, 2'b00);

    // reset values while reset is held
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, if0.req_ready}, 32'd1);
    chk("rst_valid0", {31'd0, if0.rsp_valid}, 32'd0);
    chk("rst_rdata0", if0.rsp_rdata, 32'd0);
    chk("rst_fault0", {30'd0, if0.rsp_fault}, 32'd0);
    chk("rst_ready3", {31'd0, if3.req_ready}, 32'd1);
    chk("rst_state3", {30'd0, st3}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].d, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, ft, lat, rl);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_fault", i), {30'd0, ft}, {30'd0, vecs[i].exp_fault});
      chk($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].d == 0) ? 32'd2 : 32'd5);
      chk($sformatf("v%0d_ready_low", i), 32'(rl), (vecs[i].d == 0) ? 32'd1 : 32'd4);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'd0, get_rsp_valid(vecs[i].d)}, 32'd0);
    end

    // back-to-back: second request presented in the RESP cycle of the first
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    wait_rsp(3, lat, rl);
    chk("b2b_first_lat", 32'(lat), 32'd5);
    chk("b2b_first_rdata", if3.rsp_rdata, 32'h11111111);
    drive(3, 1'b1, 1'b1, 3'b010, 32'h44, 32'h22222222);
    chk("b2b_ready_in_resp", {31'd0, if3.req_ready}, 32'd1);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("b2b_no_gap_state", {30'd0, st3}, 32'd1);
    chk("b2b_no_gap_ready", {31'd0, if3.req_ready}, 32'd0);
    wait_rsp(3, lat, rl);
    chk("b2b_second_lat", 32'(lat), 32'd5);
    chk("b2b_second_fault", {30'd0, if3.rsp_fault}, 32'd0);
    run_req(3, 1'b0, 3'b010, 32'h44, 32'h0, rd, ft, lat, rl);
    chk("b2b_readback", rd, 32'h22222222);

    // reset in the second ACCESS cycle of a pending store
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("rstmid_access1", {31'd0, if3.req_ready}, 32'd0);
    @(negedge clk);
    chk("rstmid_access2", {30'd0, st3}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_ready", {31'd0, if3.req_ready}, 32'd1);
    chk("rstmid_valid", {31'd0, if3.rsp_valid}, 32'd0);
    chk("rstmid_rdata", if3.rsp_rdata, 32'd0);
    chk("rstmid_fault", {30'd0, if3.rsp_fault}, 32'd0);
    chk("rstmid_state", {30'd0, st3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if3.rsp_valid) seen++;
    end
    chk("rstmid_no_rsp", 32'(seen), 32'd0);
    run_req(3, 1'b0, 3'b010, 32'h40, 32'h0, rd, ft, lat, rl);
    chk("rstmid_old_value", rd, 32'h11111111);
    chk("rstmid_old_lat", 32'(lat), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
